// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: redirect input, imem request/response and decode output.
// master = fetch unit side, slave = memory/decode/branch environment side.
interface fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, instr_ready,
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, instr_ready,
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited PC generator, in-order response capture into a
// DEPTH-entry fetch queue, and redirect flush with counted discard of stale responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master fetch_io
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   fpc_q;
    logic          rst_state_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] drop_cnt_q;
    logic [AW-1:0] head_q, tail_q;
    logic [AW-1:0] ahead_q, atail_q;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   addr_q [DEPTH];

    logic credit_c, req_valid_c, req_fire_c, instr_valid_c, pop_c, rsp_keep_c;

    // Outstanding requests (stale ones included) reserve queue slots, so responses never overflow.
    always_comb begin
        credit_c      = ({1'b0, count_q} + {1'b0, outstanding_q}) < (CW + 1)'(DEPTH);
        req_valid_c   = !rst_state_q && !fetch_io.redirect_valid && credit_c;
        req_fire_c    = req_valid_c && fetch_io.imem_req_ready;
        instr_valid_c = (count_q != '0) && !fetch_io.redirect_valid;
        pop_c         = instr_valid_c && fetch_io.instr_ready;
        rsp_keep_c    = fetch_io.imem_rsp_valid && (drop_cnt_q == '0) && !fetch_io.redirect_valid;
    end

    assign fetch_io.imem_req_valid = req_valid_c;
    assign fetch_io.imem_req_addr  = fpc_q;
    assign fetch_io.instr_valid    = instr_valid_c;
    assign fetch_io.instr          = data_q[head_q];
    assign fetch_io.instr_pc       = pc_q[head_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q         <= RESET_PC;
            rst_state_q   <= 1'b1;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            ahead_q       <= '0;
            atail_q       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            rst_state_q   <= 1'b0;
            outstanding_q <= outstanding_q + CW'(req_fire_c) - CW'(fetch_io.imem_rsp_valid);
            if (fetch_io.redirect_valid) begin
                // Everything still in flight, minus this cycle's response, is now stale.
                fpc_q      <= fetch_io.redirect_pc & 32'hFFFF_FFFC;
                drop_cnt_q <= outstanding_q - CW'(fetch_io.imem_rsp_valid);
                count_q    <= '0;
                head_q     <= '0;
                tail_q     <= '0;
                ahead_q    <= '0;
                atail_q    <= '0;
            end else begin
                if (req_fire_c) begin
                    fpc_q           <= fpc_q + 32'd4;
                    addr_q[atail_q] <= fpc_q;
                    atail_q         <= atail_q + AW'(1);
                end
                if (fetch_io.imem_rsp_valid && (drop_cnt_q != '0)) begin
                    drop_cnt_q <= drop_cnt_q - CW'(1);
                end
                if (rsp_keep_c) begin
                    data_q[tail_q] <= fetch_io.imem_rsp_data;
                    pc_q[tail_q]   <= addr_q[ahead_q];
                    tail_q         <= tail_q + AW'(1);
                    ahead_q        <= ahead_q + AW'(1);
                end
                if (pop_c) begin
                    head_q <= head_q + AW'(1);
                end
                count_q <= count_q + CW'(rsp_keep_c) - CW'(pop_c);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order variable-latency memory plus a queue-based
// model of the program stream (epoch-tagged requests, delivered {instr,pc} queue).
module tb_fetch_unit;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] exp_pc;
        logic [31:0] epoch;
        logic [31:0] due;
    } mreq_t;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } ment_t;

    logic clk = 1'b0;
    logic rst;

    fetch_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_io (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    mreq_t       mq[$];
    ment_t       mf[$];
    logic [31:0] mpc, epoch, cyc, last_due, redir_tgt;
    bit          warm, force_redir, redir_on_rsp, redir_hit;
    int          p_ready, p_iready, p_redir, lat_min, lat_max, fires;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // One clock cycle: drive inputs, compare outputs to the model, advance the model.
    task automatic body();
        bit          r, rsp, rdy, rq_exp, iv_exp, fire_m, fire_d;
        logic [31:0] tgt, due;
        mreq_t       e;
        ment_t       f;
        rsp = (mq.size() > 0) && (mq[0].due <= cyc);
        rdy = ($urandom_range(99) < 32'(p_ready));
        r   = 1'b0;
        tgt = $urandom;
        if (force_redir && (!redir_on_rsp || rsp)) begin
            r = 1'b1; tgt = redir_tgt; force_redir = 1'b0; redir_hit = 1'b1;
        end else if (!force_redir && ($urandom_range(99) < 32'(p_redir))) begin
            r = 1'b1;
        end
        bus.redirect_valid = r;
        bus.redirect_pc    = tgt;
        bus.imem_req_ready = rdy;
        bus.instr_ready    = ($urandom_range(99) < 32'(p_iready));
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? memfn(mq[0].addr) : $urandom;
        #1;
        rq_exp = warm && !r && (mf.size() + mq.size() < int'(DEPTH));
        iv_exp = !r && (mf.size() > 0);
        check_eq("req_valid", 32'(bus.imem_req_valid), 32'(rq_exp));
        check_eq("req_addr", bus.imem_req_addr, mpc);
        check_eq("instr_valid", 32'(bus.instr_valid), 32'(iv_exp));
        if (iv_exp) begin
            check_eq("instr", bus.instr, mf[0].data);
            check_eq("instr_pc", bus.instr_pc, mf[0].pc);
        end
        fire_d = bus.imem_req_valid && rdy;
        fire_m = rq_exp && rdy;
        if (fire_d) fires++;
        if (iv_exp && bus.instr_ready) void'(mf.pop_front());
        if (rsp) begin
            e = mq.pop_front();
            if (!r && e.epoch == epoch) begin
                f.data = memfn(e.exp_pc);
                f.pc   = e.exp_pc;
                mf.push_back(f);
            end
        end
        if (fire_d) begin
            due = cyc + 32'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 32'd1;
            last_due = due;
            e.addr = bus.imem_req_addr; e.exp_pc = mpc; e.epoch = epoch; e.due = due;
            mq.push_back(e);
        end
        if (r) begin
            mf.delete();
            epoch = epoch + 32'd1;
            mpc   = tgt & 32'hFFFF_FFFC;
        end else if (fire_m) begin
            mpc = mpc + 32'd4;
        end
        warm = 1'b1;
        cyc  = cyc + 32'd1;
    endtask

    task automatic cycle();
        @(negedge clk);
        body();
    endtask

    task automatic model_reset();
        mq.delete(); mf.delete();
        mpc = RESET_PC; warm = 1'b0; last_due = cyc;
        bus.redirect_valid = 1'b0; bus.imem_rsp_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        check_eq({tag, "_req_addr"}, bus.imem_req_addr, RESET_PC);
        check_eq({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
        check_eq({tag, "_instr"}, bus.instr, 32'd0);
        check_eq({tag, "_instr_pc"}, bus.instr_pc, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        body();
    endtask

    initial begin
        epoch = 0; cyc = 0; fires = 0;
        force_redir = 1'b0; redir_on_rsp = 1'b0; redir_hit = 1'b0; redir_tgt = 0;
        p_ready = 100; p_iready = 100; p_redir = 0; lat_min = 1; lat_max = 1;
        bus.redirect_pc = 0; bus.imem_req_ready = 1'b1; bus.imem_rsp_data = 0;
        bus.instr_ready = 1'b1;
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("rst");

        // Straight-line stream, latency 1, always ready.
        release_reset();
        repeat (20) cycle();

        // Decode back-pressure: after a flush only DEPTH requests may issue.
        p_iready = 0;
        redir_tgt = 32'h40; redir_on_rsp = 1'b0; force_redir = 1'b1;
        cycle();
        fires = 0;
        repeat (12) cycle();
        check_eq("bp_issued", 32'(fires), 32'(DEPTH));
        check_eq("bp_head_pc", bus.instr_pc, 32'h40);
        p_iready = 100;
        repeat (10) cycle();

        // Redirect with three responses in flight.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && mq.size() != 3; i++) cycle();
        check_eq("inflight_3", 32'(mq.size()), 32'd3);
        redir_tgt = 32'h100; force_redir = 1'b1;
        repeat (15) cycle();

        // Redirect in the same cycle as a response, unaligned target.
        lat_min = 2; lat_max = 2;
        redir_hit = 1'b0; redir_tgt = 32'h203; redir_on_rsp = 1'b1; force_redir = 1'b1;
        for (int i = 0; i < 20 && force_redir; i++) cycle();
        check_eq("redir_on_rsp_hit", 32'(redir_hit), 32'd1);
        force_redir = 1'b0; redir_on_rsp = 1'b0;
        repeat (10) cycle();

        // Memory stall, then wrap-around from the top of the address space.
        p_ready = 0;
        repeat (5) cycle();
        p_ready = 100; lat_min = 1; lat_max = 1;
        redir_tgt = 32'hFFFF_FFFC; force_redir = 1'b1;
        repeat (10) cycle();

        // Randomized traffic.
        for (int blk = 0; blk < 15; blk++) begin
            p_ready  = int'($urandom_range(100, 30));
            p_iready = int'($urandom_range(100, 20));
            p_redir  = int'($urandom_range(5, 0));
            lat_min  = int'($urandom_range(3, 1));
            lat_max  = lat_min + int'($urandom_range(3, 0));
            repeat (100) cycle();
        end

        // Asynchronous reset mid-stream.
        p_ready = 100; p_iready = 100; p_redir = 0; lat_min = 1; lat_max = 2;
        repeat (8) cycle();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        model_reset();
        repeat (2) @(negedge clk);
        release_reset();
        repeat (20) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
